step_key_ctrl: RTL and testbench
================================

STEP_KEY_CTRL -- requirements
Module: step_key_ctrl

Interface
REQ-001 Parameter DEB_TICKS, default 4: number of consecutive stable tick samples before a key change is accepted (range 1..65535).
REQ-002 Parameter HOLD_TICKS, default 50: ticks a key is held after its first pulse before auto-repeat starts (range 1..65535).
REQ-003 Parameter REPEAT_TICKS, default 10: ticks between auto-repeat pulses (range 1..65535).
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 tick  input  1  one-cycle timebase strobe; all debounce, hold and repeat timing counts tick cycles only.
REQ-007 key_up  input  1  raw asynchronous "up" button, active-high, may bounce.
REQ-008 key_dn  input  1  raw asynchronous "down" button, active-high, may bounce.
REQ-009 add  output  1  one-clk pulse requesting +step; drives the digit adder add input.
REQ-010 sub  output  1  one-clk pulse requesting -step; drives the digit adder sub input.
REQ-011 held  output  1  high while the FSM is in PRESS, HOLD or REPEAT.

Function
REQ-012 Each key passes through a two-flop synchronizer before any other logic, giving 2 clk input latency.
REQ-013 Per key, a debounced level changes only after the synchronized value differs from it on DEB_TICKS consecutive tick cycles; any tick sample equal to the debounced level clears that key's counter.
REQ-014 The FSM has four states: IDLE, PRESS, HOLD, REPEAT, plus a LOCK state for conflicts.
REQ-015 IDLE: exactly one debounced key high -> PRESS, capturing that key as the direction; both keys high -> LOCK.
REQ-016 PRESS lasts one clk and asserts the captured pulse (add or sub) in that cycle, then moves to HOLD with the hold counter cleared.
REQ-017 HOLD counts ticks; when the count reaches HOLD_TICKS with the key still down, the FSM moves to REPEAT with the repeat counter cleared.
REQ-018 REPEAT counts ticks; each time the count reaches REPEAT_TICKS, it emits one pulse in the same direction on the following clk and restarts the count from 0.
REQ-019 In HOLD or REPEAT, release of the captured debounced key -> IDLE on the next clk with no pulse; a pending partial count is discarded.
REQ-020 In HOLD or REPEAT, the opposite debounced key going high -> LOCK with no further pulses.
REQ-021 LOCK: no pulses; exit to IDLE only after both debounced keys are low.
REQ-022 add and sub are never high in the same cycle, and each pulse is exactly one clk wide regardless of the tick rate.
REQ-023 Counters are 16 bits wide and saturate, never wrapping; a tick arriving in the same cycle as a state change is counted by the new state.
REQ-024 Latency from a clean key press to the add/sub pulse is 2 clk synchronizer + DEB_TICKS ticks + 1 clk FSM.

Reset
REQ-025 While rst_n=0 at a rising clk edge: add=0, sub=0, held=0, FSM=IDLE, debounced levels=0, all counters=0, and synchronizer flops=0.
REQ-026 Reset asserted mid-HOLD or mid-REPEAT aborts without any pulse; after release, a key still held is re-debounced from 0 and produces a fresh PRESS pulse.
REQ-027 tick and key inputs are ignored while rst_n=0.

Verification (defaults DEB=4, HOLD=50, REPEAT=10, tick every 4 clk)
REQ-028 Clean key_up press held for 8 ticks, then released -> exactly one add pulse, 1 clk wide, about 4 ticks plus 3 clk after the press; sub=0 throughout.
REQ-029 key_dn bouncing 0/1 every tick for 10 ticks, then stable high for 5 ticks -> no sub pulse during the bounce, then exactly one sub pulse.
REQ-030 key_up held for 50+35 ticks -> one add pulse at PRESS, then 3 repeat pulses spaced exactly 10 ticks apart; held=1 throughout.
REQ-031 key_up held, then key_dn pressed during REPEAT -> no more pulses, held=0 (LOCK); release only key_up -> still no pulses; release key_dn -> IDLE.
REQ-032 rst_n pulled low for 1 clk during REPEAT while key_up stays held -> no pulse in the reset cycle, all outputs 0, then one add pulse 4 ticks plus 3 clk after release.
REQ-033 Both keys pressed in the same cycle from IDLE -> no add or sub pulse ever, until both keys are released and one is pressed again.

Source files
------------

// File: rtl/step_key_ctrl.sv
// Up/down step-key controller: synchronizes and debounces two buttons, then turns
// a press into one add/sub pulse followed by tick-timed auto-repeat while held.
module step_key_ctrl #(
   parameter int unsigned DEB_TICKS    = 4,
   parameter int unsigned HOLD_TICKS   = 50,
   parameter int unsigned REPEAT_TICKS = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       key_up,
   input  logic       key_dn,
   output logic       add,
   output logic       sub,
   output logic       held,
   output logic [2:0] o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PRESS  = 3'd1,
      S_HOLD   = 3'd2,
      S_REPEAT = 3'd3,
      S_LOCK   = 3'd4
   } state_t;

   localparam logic [15:0] DEB_LIM  = 16'(DEB_TICKS);
   localparam logic [15:0] HOLD_LIM = 16'(HOLD_TICKS);
   localparam logic [15:0] REP_LIM  = 16'(REPEAT_TICKS);

   // Bit 0 carries the up key, bit 1 the down key throughout.
   logic [1:0]  r_meta;
   logic [1:0]  r_sync;
   logic [1:0]  r_db;
   logic [15:0] r_deb_cnt [2];
   logic [15:0] w_deb_inc [2];

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_dir;
   logic        w_dir_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic [15:0] w_cnt_inc;
   logic        r_rep;
   logic        w_rep_nxt;
   logic        w_captured;
   logic        w_opposite;
   logic        w_pulse;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= {key_dn, key_up};
         r_sync <= r_meta;
      end
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_deb_inc[i] = (r_deb_cnt[i] == 16'hFFFF) ? r_deb_cnt[i] : r_deb_cnt[i] + 16'd1;
      end
   end

   // A tick sample that agrees with the debounced level restarts the run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_db         <= '0;
         r_deb_cnt[0] <= '0;
         r_deb_cnt[1] <= '0;
      end else if (tick) begin
         for (int i = 0; i < 2; i++) begin
            if (r_sync[i] == r_db[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (w_deb_inc[i] >= DEB_LIM) begin
               r_db[i]      <= r_sync[i];
               r_deb_cnt[i] <= '0;
            end else begin
               r_deb_cnt[i] <= w_deb_inc[i];
            end
         end
      end
   end

   assign w_captured = r_dir ? r_db[1] : r_db[0];
   assign w_opposite = r_dir ? r_db[0] : r_db[1];
   assign w_cnt_inc  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + {15'd0, tick};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_dir   <= 1'b0;
         r_cnt   <= '0;
         r_rep   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dir   <= w_dir_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rep   <= w_rep_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dir_nxt   = r_dir;
      w_cnt_nxt   = r_cnt;
      w_rep_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (r_db == 2'b11) begin
               w_state_nxt = S_LOCK;
            end else if (r_db != 2'b00) begin
               w_state_nxt = S_PRESS;
               w_dir_nxt   = r_db[1];
            end
         end
         S_PRESS: begin
            // A tick coinciding with the move to HOLD is counted by HOLD.
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = {15'd0, tick};
         end
         S_HOLD, S_REPEAT: begin
            if (w_opposite) begin
               w_state_nxt = S_LOCK;
               w_cnt_nxt   = '0;
            end else if (!w_captured) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_state == S_HOLD && w_cnt_inc >= HOLD_LIM) begin
               w_state_nxt = S_REPEAT;
               w_cnt_nxt   = '0;
            end else if (r_state == S_REPEAT && w_cnt_inc >= REP_LIM) begin
               w_rep_nxt = 1'b1;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         S_LOCK: begin
            w_cnt_nxt = '0;
            if (r_db == 2'b00) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are gated by rst_n so a reset cycle never shows a pulse.
   assign w_pulse     = (r_state == S_PRESS) | r_rep;
   assign add         = rst_n & w_pulse & ~r_dir;
   assign sub         = rst_n & w_pulse & r_dir;
   assign held        = rst_n & ((r_state == S_PRESS) | (r_state == S_HOLD) | (r_state == S_REPEAT));
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_step_key_ctrl.sv
// Bench for step_key_ctrl: directed key scenarios plus random key/tick traffic,
// checked every cycle against a tick-count model of the key behaviour.
module tb_step_key_ctrl;

   localparam int DEB    = 4;
   localparam int HOLD   = 50;
   localparam int REPEAT = 10;

   logic       clk;
   logic       rst_n;
   logic       tick;
   logic       key_up;
   logic       key_dn;
   logic       add;
   logic       sub;
   logic       held;
   logic [2:0] dbg_state;

   int n_checks;
   int n_fail;
   int cyc;
   int add_cnt;
   int sub_cnt;
   int add_times[$];
   int press_cyc;
   bit rand_tick;
   int tick_phase;

   step_key_ctrl #(
      .DEB_TICKS   (DEB),
      .HOLD_TICKS  (HOLD),
      .REPEAT_TICKS(REPEAT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .key_up     (key_up),
      .key_dn     (key_dn),
      .add        (add),
      .sub        (sub),
      .held       (held),
      .o_dbg_state(dbg_state)
   );

   // ---------------- clock / tick ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      tick       = 1'b0;
      tick_phase = 0;
      forever begin
         @(negedge clk);
         if (rand_tick) tick = ($urandom_range(0, 2) == 0);
         else           tick = (tick_phase == 3);
         tick_phase = (tick_phase + 1) % 4;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural model ----------------
   // mode: 0 = no key accepted, 1 = key accepted (press/hold/repeat), 2 = conflict lock.
   // m_n counts ticks since the press pulse; repeats fall every REPEAT ticks after HOLD.
   bit m_meta[2];
   bit m_sync[2];
   bit m_db[2];
   int m_run[2];
   int m_mode;
   bit m_dir;
   bit m_first;
   bit m_due;
   int m_n;
   int nn;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_meta[i] <= 1'b0;
            m_sync[i] <= 1'b0;
            m_db[i]   <= 1'b0;
            m_run[i]  <= 0;
         end
         m_mode  <= 0;
         m_dir   <= 1'b0;
         m_first <= 1'b0;
         m_due   <= 1'b0;
         m_n     <= 0;
      end else begin
         m_due <= 1'b0;
         if (m_mode == 0) begin
            m_n <= 0;
            if (m_db[0] && m_db[1]) begin
               m_mode <= 2;
            end else if (m_db[0] || m_db[1]) begin
               m_mode  <= 1;
               m_dir   <= m_db[1];
               m_first <= 1'b1;
            end
         end else if (m_mode == 1) begin
            if (m_first) begin
               m_first <= 1'b0;
               m_n     <= tick ? 1 : 0;
            end else if (m_db[!m_dir]) begin
               m_mode <= 2;
            end else if (!m_db[m_dir]) begin
               m_mode <= 0;
            end else begin
               nn = m_n + (tick ? 1 : 0);
               m_n   <= nn;
               m_due <= tick && (nn > HOLD) && ((nn - HOLD) % REPEAT == 0);
            end
         end else begin
            if (!m_db[0] && !m_db[1]) m_mode <= 0;
         end
         for (int i = 0; i < 2; i++) begin
            if (tick) begin
               if (m_sync[i] == m_db[i]) begin
                  m_run[i] <= 0;
               end else if (m_run[i] + 1 >= DEB) begin
                  m_db[i]  <= m_sync[i];
                  m_run[i] <= 0;
               end else begin
                  m_run[i] <= m_run[i] + 1;
               end
            end
         end
         m_meta[0] <= key_up;
         m_meta[1] <= key_dn;
         m_sync[0] <= m_meta[0];
         m_sync[1] <= m_meta[1];
      end
   end

   logic exp_add;
   logic exp_sub;
   logic exp_held;
   assign exp_held = rst_n && (m_mode == 1);
   assign exp_add  = exp_held && !m_dir && (m_first || m_due);
   assign exp_sub  = exp_held && m_dir && (m_first || m_due);

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      check("add", int'(add), int'(exp_add));
      check("sub", int'(sub), int'(exp_sub));
      check("held", int'(held), int'(exp_held));
      if (add) begin
         add_cnt++;
         add_times.push_back(cyc);
      end
      if (sub) sub_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      clks(4 * n);
   endtask

   task automatic clear_counts();
      add_cnt = 0;
      sub_cnt = 0;
      add_times.delete();
   endtask

   task automatic random_traffic(input int episodes);
      int target;
      int dur;
      for (int e = 0; e < episodes; e++) begin
         target = $urandom_range(0, 3);
         dur    = $urandom_range(4, 300);
         if ($urandom_range(0, 15) == 0) begin
            rst_n = 1'b0;
            clks($urandom_range(1, 3));
            rst_n = 1'b1;
         end
         for (int c = 0; c < dur; c++) begin
            @(negedge clk);
            key_up = ($urandom_range(0, 15) == 0) ? !target[0] : target[0];
            key_dn = ($urandom_range(0, 15) == 0) ? !target[1] : target[1];
         end
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      n_checks  = 0;
      n_fail    = 0;
      cyc       = 0;
      rand_tick = 1'b0;
      rst_n     = 1'b0;
      key_up    = 1'b0;
      key_dn    = 1'b0;
      clear_counts();
      clks(5);
      check("rst_add", int'(add), 0);
      check("rst_sub", int'(sub), 0);
      check("rst_held", int'(held), 0);
      check("rst_state_idle", int'(dbg_state), 0);
      rst_n = 1'b1;
      clks(3);

      // Clean single press, released after 8 ticks.
      clear_counts();
      key_up    = 1'b1;
      press_cyc = cyc;
      ticks(8);
      key_up = 1'b0;
      ticks(8);
      check("clean_add_count", add_cnt, 1);
      check("clean_sub_count", sub_cnt, 0);
      check("clean_latency_ok",
            (add_times.size() == 1 && add_times[0] - press_cyc >= 14 && add_times[0] - press_cyc <= 20) ? 1 : 0, 1);

      // Bouncing down key, then stable.
      clear_counts();
      for (int i = 0; i < 10; i++) begin
         key_dn = (i % 2 == 0);
         ticks(1);
      end
      check("bounce_no_sub", sub_cnt, 0);
      key_dn = 1'b1;
      ticks(5);
      key_dn = 1'b0;
      ticks(8);
      check("bounce_one_sub", sub_cnt, 1);
      check("bounce_no_add", add_cnt, 0);

      // Long hold: press pulse plus three repeats 10 ticks apart.
      clear_counts();
      key_up = 1'b1;
      ticks(85);
      key_up = 1'b0;
      ticks(10);
      check("repeat_add_count", add_cnt, 4);
      check("repeat_gap1", (add_times.size() >= 4) ? add_times[2] - add_times[1] : -1, 4 * REPEAT);
      check("repeat_gap2", (add_times.size() >= 4) ? add_times[3] - add_times[2] : -1, 4 * REPEAT);

      // Opposite key during repeat locks out pulses.
      key_up = 1'b1;
      ticks(65);
      key_dn = 1'b1;
      ticks(8);
      clear_counts();
      check("lock_held_low", int'(held), 0);
      key_up = 1'b0;
      ticks(8);
      check("lock_no_add", add_cnt, 0);
      check("lock_still_locked", int'(dbg_state), 4);
      key_dn = 1'b0;
      ticks(8);
      check("lock_exit_idle", int'(dbg_state), 0);
      check("lock_no_sub", sub_cnt, 0);

      // Reset during repeat, key still held: fresh press pulse after release.
      key_up = 1'b1;
      ticks(70);
      clear_counts();
      rst_n = 1'b0;
      clks(1);
      rst_n = 1'b1;
      ticks(10);
      check("reset_repress_add", add_cnt, 1);
      key_up = 1'b0;
      ticks(8);

      // Simultaneous press from idle.
      clear_counts();
      key_up = 1'b1;
      key_dn = 1'b1;
      ticks(20);
      check("both_no_pulse", add_cnt + sub_cnt, 0);
      check("both_not_held", int'(held), 0);
      key_up = 1'b0;
      key_dn = 1'b0;
      ticks(8);
      key_dn = 1'b1;
      ticks(8);
      key_dn = 1'b0;
      ticks(8);
      check("both_then_sub", sub_cnt, 1);
      check("both_then_no_add", add_cnt, 0);

      // Random keys, bounces, resets and irregular ticks.
      rand_tick = 1'b1;
      random_traffic(60);
      key_up = 1'b0;
      key_dn = 1'b0;
      clks(100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
